// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample bridge.
// Default widths match a 24-bit stereo I2S path.
package audio_pkg;

  localparam int CODEC_W  = 32;
  localparam int SAMPLE_W = 24;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [chan_w(2)-1:0] chan_t;

  typedef struct packed {
    chan_t   ch;
    sample_t d;
  } entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with flush; extra pointer MSB separates full from empty.
// Read data is the head entry, valid whenever empty is low.
module sample_fifo import audio_pkg::*; #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_stream_bridge.sv
// I2S sample bridge: channel-tagged RX buffering toward the core,
// TX buffering toward the DAC with attenuation, bypass and fault flags.
module audio_stream_bridge import audio_pkg::*; #(
  parameter int CODEC_WIDTH  = CODEC_W,
  parameter int SAMPLE_WIDTH = SAMPLE_W,
  parameter int SAMPLE_LSB   = 0,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        lmmi_clk_i,
  input  logic                        reset_n_i,
  input  logic                        enable_i,
  input  logic                        bypass_i,
  input  logic [3:0]                  conf_shift_i,
  input  logic                        clr_status_i,
  input  logic                        ws_i,
  input  logic [CODEC_WIDTH-1:0]      adc_data_i,
  input  logic                        adc_valid_i,
  output logic [SAMPLE_WIDTH-1:0]     m_data_o,
  output logic [chan_w(NUM_CH)-1:0]   m_ch_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  input  logic [SAMPLE_WIDTH-1:0]     s_data_i,
  input  logic [chan_w(NUM_CH)-1:0]   s_ch_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic                        dac_request_i,
  output logic [CODEC_WIDTH-1:0]      dac_data_o,
  output logic                        rx_ovf_o,
  output logic                        tx_udf_o,
  output logic                        tx_misalign_o
);

  localparam int CW = chan_w(NUM_CH);
  localparam int EW = CW + SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  function automatic logic [CW-1:0] ch_next(input logic [CW-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  logic [2:0]    ws_sr;
  logic          ws_fall;
  logic          sync_q;
  logic          run_q;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_tag;

  logic [EW-1:0] rx_din, rx_dout, tx_din, tx_dout;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [AW:0]   rx_count, tx_count;
  logic          move, serve;

  logic [CW-1:0]                  tx_ch;
  logic signed [SAMPLE_WIDTH-1:0] tx_smp;
  logic signed [SAMPLE_WIDTH-1:0] tx_shf;
  logic [CODEC_WIDTH-1:0]         slot;
  logic ovf_evt, udf_evt, mis_evt;
  logic unused_bits;

  assign unused_bits = ^adc_data_i;

  assign ws_fall = ws_sr[2] & ~ws_sr[1];
  assign rx_tag  = sync_q ? '0 : rx_cnt;
  assign rx_push = adc_valid_i & enable_i;
  assign rx_din  = {rx_tag, adc_data_i[SAMPLE_LSB +: SAMPLE_WIDTH]};

  // Bypass moves one entry per cycle straight from RX to TX.
  assign move = enable_i & bypass_i &
                (rx_count != '0) & (tx_count != FULL_CNT);

  assign m_valid_o = enable_i & ~bypass_i & ~rx_empty;
  assign m_data_o  = rx_dout[SAMPLE_WIDTH-1:0];
  assign m_ch_o    = rx_dout[EW-1 -: CW];
  assign rx_pop    = move | (m_valid_o & m_ready_i);
  assign ovf_evt   = rx_push & rx_full & ~rx_pop;

  assign s_ready_o = run_q & enable_i & ~bypass_i & ~tx_full;
  assign tx_push   = move | (s_valid_i & s_ready_o);
  assign tx_din    = bypass_i ? rx_dout : {s_ch_i, s_data_i};

  assign serve   = dac_request_i & enable_i;
  assign tx_pop  = serve;
  assign tx_ch   = tx_dout[EW-1 -: CW];
  assign tx_smp  = tx_dout[SAMPLE_WIDTH-1:0];
  assign tx_shf  = tx_smp >>> conf_shift_i;
  assign udf_evt = serve & tx_empty;
  assign mis_evt = serve & ~tx_empty & (tx_ch != tx_cnt);

  always_comb begin
    slot = '0;
    slot[SAMPLE_LSB +: SAMPLE_WIDTH] = tx_shf;
  end

  sample_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (lmmi_clk_i),
    .rst_n (reset_n_i),
    .flush (~enable_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_din),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sample_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (lmmi_clk_i),
    .rst_n (reset_n_i),
    .flush (~enable_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ws_sr  <= '0;
      sync_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      ws_sr  <= {ws_sr[1:0], ws_i};
      sync_q <= ws_fall | (sync_q & ~rx_push);
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else if (!enable_i) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (adc_valid_i) rx_cnt <= ch_next(rx_tag);
      if (serve) tx_cnt <= tx_empty ? ch_next(tx_cnt) : ch_next(tx_ch);
    end
  end

  // A new fault in the clearing cycle keeps its flag set.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dac_data_o    <= '0;
      rx_ovf_o      <= 1'b0;
      tx_udf_o      <= 1'b0;
      tx_misalign_o <= 1'b0;
    end else begin
      if (dac_request_i)
        dac_data_o <= (serve & ~tx_empty) ? slot : '0;
      rx_ovf_o      <= ovf_evt | (rx_ovf_o & ~clr_status_i);
      tx_udf_o      <= udf_evt | (tx_udf_o & ~clr_status_i);
      tx_misalign_o <= mis_evt | (tx_misalign_o & ~clr_status_i);
    end
  end

endmodule

// File: doc/audio_stream_bridge.md
Name: audio_stream_bridge

Overview:
- Parametrised sample bridge that sits between the I2S receive codec, the processing core (EQ/filters) and the I2S transmit codec.
- Tags each ADC sample with its channel, buffers it in an RX FIFO and hands it to the processing core over valid/ready.
- Buffers processed samples in a TX FIFO and serves them to the DAC codec on request, with output attenuation, bypass and sticky fault flags.
- Replaces the single free-running latch with N-channel, flow-controlled, depth-configurable buffering.

Parameters:
- CODEC_WIDTH, 32, width of the codec sample_dat bus.
- SAMPLE_WIDTH, 24, width of samples on the processing-side streams.
- SAMPLE_LSB, 0, bit of the codec word where the sample starts; must satisfy SAMPLE_LSB+SAMPLE_WIDTH <= CODEC_WIDTH.
- NUM_CH, 2, channels per frame (2 = stereo; up to 8 for TDM).
- FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.

Ports:
- lmmi_clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  bridge enable; low flushes both FIFOs and resets both channel counters.
- bypass_i  in  1  when high, RX FIFO output feeds TX FIFO input directly; processing streams are idle.
- conf_shift_i  in  4  TX arithmetic right-shift amount, 0..15.
- clr_status_i  in  1  single-cycle pulse; clears all sticky flags.
- ws_i  in  1  I2S word select, used for frame alignment.
- adc_data_i  in  CODEC_WIDTH  RX codec sample.
- adc_valid_i  in  1  RX codec sample strobe, one cycle.
- m_data_o  out  SAMPLE_WIDTH  signed sample to the processing core.
- m_ch_o  out  $clog2(NUM_CH)  channel tag of m_data_o.
- m_valid_o  out  1  valid for the m_* stream.
- m_ready_i  in  1  ready from the processing core.
- s_data_i  in  SAMPLE_WIDTH  processed signed sample.
- s_ch_i  in  $clog2(NUM_CH)  channel tag of s_data_i.
- s_valid_i  in  1  valid for the s_* stream.
- s_ready_o  out  1  TX FIFO not full (and bypass_i low).
- dac_request_i  in  1  TX codec sample request strobe, one cycle.
- dac_data_o  out  CODEC_WIDTH  sample to the TX codec.
- rx_ovf_o  out  1  sticky: RX FIFO overflow.
- tx_udf_o  out  1  sticky: TX FIFO underflow.
- tx_misalign_o  out  1  sticky: channel-order error on the TX side.

Behaviour:
- Reset (asynchronous): both FIFOs empty; both channel counters 0; m_valid_o=0; s_ready_o=0; dac_data_o=0; all sticky flags 0.
- ws_i is registered twice before use. A falling edge (left/slot 0 start) arms the sync flag. The next adc_valid_i is tagged channel 0 and clears the flag. Otherwise the RX channel counter increments per adc_valid_i and wraps at NUM_CH-1.
- RX capture: on adc_valid_i with enable_i high, push {ch, adc_data_i[SAMPLE_LSB +: SAMPLE_WIDTH]} into the RX FIFO. If the FIFO is full, drop the new sample (existing contents are kept), set rx_ovf_o, and still advance the channel counter.
- m_* stream:
  - m_valid_o is asserted whenever the RX FIFO is non-empty and bypass_i is low.
  - A pop occurs on m_valid_o && m_ready_i.
  - m_data_o and m_ch_o are stable while m_valid_o is high and m_ready_i is low.
  - Latency from capture to m_valid_o is 1 cycle when the FIFO was empty.
- s_* stream: push on s_valid_i && s_ready_o.
- Bypass: each cycle, when the RX FIFO is non-empty and the TX FIFO is not full, move one entry RX->TX. Toggle bypass_i only while enable_i is low; behaviour otherwise is undefined and not checked.
- TX serve: on dac_request_i, one cycle later dac_data_o is updated.
  - If the TX FIFO is non-empty: pop the entry, compute v = sample >>> conf_shift_i (sign-preserving), and place v at [SAMPLE_LSB +: SAMPLE_WIDTH]; all other bits are 0.
  - Compare the popped channel with the TX channel counter. On mismatch set tx_misalign_o, then resync the counter to popped ch+1.
  - If the TX FIFO is empty: dac_data_o=0 (mute), set tx_udf_o, and still advance the TX channel counter.
  - dac_data_o holds its value between requests.
- Simultaneous push and pop on the same FIFO when it is full or empty:
  - Full plus pop: both succeed and the count is unchanged.
  - Empty plus push plus pop request: no pop occurs (no fall-through); the push succeeds.
- Simultaneous clr_status_i and a new fault event: the fault wins and the flag stays set.
- enable_i low: FIFOs are flushed in one cycle; counters go to 0; m_valid_o=0; s_ready_o=0; dac_request_i produces dac_data_o=0 with no underflow flag; sticky flags are retained.
- Pointer wrap: read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide; full/empty are decided from the extra MSB.

Decomposition:
- Package audio_pkg: sample_t (signed [SAMPLE_WIDTH-1:0]), chan_t width function, CODEC_WIDTH constant, tagged-entry struct {chan_t ch; sample_t d}.
- One sub-module, sample_fifo (parametrised synchronous FIFO with flush, full, empty and count outputs), instantiated twice, for RX and TX.
- Channel counters and ws edge detection stay inline.

Test Plan:
- Stereo alignment: ws falls, then adc_valid samples 0x000100 and 0xFFFF00 -> m_* emits (ch0, 0x000100) then (ch1, 0xFFFF00).
- Overflow: FIFO_DEPTH=4, m_ready_i=0, 5 adc_valid strobes -> 4 entries retained (the first four), rx_ovf_o=1; clr_status_i -> rx_ovf_o=0.
- Attenuation: bypass, conf_shift_i=3, sample 0x800000 -> dac_data_o=0x00F00000 in 24-bit slot with SAMPLE_LSB=0 (value 0xF00000); 0x000010 -> 0x000002.
- Underflow: dac_request_i with empty TX FIFO -> dac_data_o=0 and tx_udf_o=1 one cycle later; the next pushed ch1 sample is served without misalign.
- Misalignment: push ch1 first, then dac_request_i -> tx_misalign_o=1; subsequent ch0 is accepted in order with no further flag.
- Asynchronous reset mid-stream: assert reset_n_i with 3 entries queued -> FIFOs empty, dac_data_o=0 and flags 0 immediately, without waiting for a clock edge.
